// File: rtl/if_inst_buffer_pkg.sv
// Shared definitions for the IF2/ID instruction buffer: widths, reset PC,
// entry layout {adef, pc, inst} and an entry packing helper.
package if_inst_buffer_pkg;

    localparam logic [31:0] PC_INITIAL = 32'h1c00_0000;

    localparam int INST_W       = 32;
    localparam int PC_W         = 32;
    localparam int IBUF_ENTRY_W = 65;

    // Entry field bit positions: adef is the MSB, then pc, then inst.
    localparam int ENTRY_ADEF_BIT = 64;
    localparam int ENTRY_PC_MSB   = 63;
    localparam int ENTRY_PC_LSB   = 32;
    localparam int ENTRY_INST_MSB = 31;
    localparam int ENTRY_INST_LSB = 0;

    typedef struct packed {
        logic              adef;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ibuf_entry_t;

    function automatic ibuf_entry_t make_entry(input logic              adef,
                                               input logic [PC_W-1:0]   pc,
                                               input logic [INST_W-1:0] inst);
        ibuf_entry_t e;
        e.adef = adef;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/if_inst_buffer_if.sv
// Fetch-side and decode-side handshake of the instruction buffer.
// slave = buffer view, master = fetch/decode environment view.
interface if_inst_buffer_if;
    import if_inst_buffer_pkg::*;

    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_adef;
    logic              pc_wen;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_adef;

    modport master (
        output in_valid, in_pc, in_inst, in_adef, out_ready,
        input  pc_wen, out_valid, out_pc, out_inst, out_adef
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_adef, out_ready,
        output pc_wen, out_valid, out_pc, out_inst, out_adef
    );

endinterface

// File: rtl/if_inst_buffer_mem.sv
// ibuf_mem: DEPTH-entry register array for the instruction buffer,
// one write port and one combinational read port. Contents are not reset.
module ibuf_mem
    import if_inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ibuf_entry_t   wdata,
    input  logic [AW-1:0] raddr,
    output ibuf_entry_t   rdata
);

    ibuf_entry_t mem [DEPTH];

    // Write the incoming fetch entry at the tail slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_inst_buffer.sv
// IF2/ID instruction fetch buffer: circular queue of {pc, inst, adef}
// with fetch backpressure (pc_wen), flush and a post-flush drop window
// that discards wrong-path fetches still in flight.
// Optional build macro IBUF_BYPASS_EN: forwards an arriving fetch straight
// to decode when the buffer is empty.
module if_inst_buffer
    import if_inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SKID  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    if_inst_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(SKID + 2);

    // pc_wen stays high while more than SKID slots are free.
    localparam logic [CW-1:0] WEN_LIMIT = CW'(DEPTH - SKID);
    localparam logic [DW-1:0] SKID_LD   = DW'(SKID);

    logic [AW:0]   head;
    logic [AW:0]   tail;
    logic [DW-1:0] drop_cnt;

    logic        empty;
    logic        full;
    logic        accept_ok;
    logic        bypass;
    logic        pop;
    logic        push;
    logic        mem_we;
    logic        head_adv;
    ibuf_entry_t in_entry;
    ibuf_entry_t head_entry;
    ibuf_entry_t out_entry;

    ibuf_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (tail[AW-1:0]),
        .wdata (in_entry),
        .raddr (head[AW-1:0]),
        .rdata (head_entry)
    );

    // Queue status, handshake decode and bypass selection.
    always_comb begin
        empty     = (head == tail);
        full      = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
        accept_ok = bus.in_valid && !flush && (drop_cnt == '0);
        in_entry  = make_entry(bus.in_adef, bus.in_pc, bus.in_inst);
`ifdef IBUF_BYPASS_EN
        bypass    = accept_ok && empty;
`else
        bypass    = 1'b0;
`endif
        // out_ready is ignored while flushing.
        pop       = (!empty || bypass) && bus.out_ready && !flush;
        push      = accept_ok && (!full || pop);
        // A bypassed entry consumed in the same cycle never touches storage.
        mem_we    = push && !(bypass && bus.out_ready);
        head_adv  = pop && !empty;
        out_entry = bypass ? in_entry : head_entry;
    end

    // Decode-side outputs, zeroed when nothing is presented.
    always_comb begin
        bus.out_valid = !empty || bypass;
        bus.out_pc    = '0;
        bus.out_inst  = '0;
        bus.out_adef  = 1'b0;
        if (bus.out_valid) begin
            bus.out_pc   = out_entry.pc;
            bus.out_adef = out_entry.adef;
            bus.out_inst = out_entry.adef ? '0 : out_entry.inst;
        end
        bus.pc_wen = (count < WEN_LIMIT);
    end

    // Pointer, occupancy and drop-window state; flush outranks everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= SKID_LD;
        end else begin
            if (mem_we) begin
                tail <= tail + (AW+1)'(1);
            end
            if (head_adv) begin
                head <= head + (AW+1)'(1);
            end
            count <= count + CW'(mem_we) - CW'(head_adv);
            if (drop_cnt != '0) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_inst_buffer.sv
// Testbench for if_inst_buffer: table-driven fill/drain vectors,
// hand-written flush/adef/reset sequences and randomized traffic,
// all compared against a queue-based reference model.
module tb_if_inst_buffer;
    import if_inst_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int SKID  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] count;

    if_inst_buffer_if bus();

    if_inst_buffer #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored entries plus drop-window counter.
    ibuf_entry_t mq[$];
    int          drop = 0;

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic        ready;
        logic        exp_valid;
        int          exp_count;
        logic        exp_wen;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_bypass();
`ifdef IBUF_BYPASS_EN
        return (mq.size() == 0) && bus.in_valid && !flush && (drop == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Compare all DUT outputs with what the model says for the current inputs.
    task automatic model_check();
        logic        byp;
        logic        ev;
        ibuf_entry_t h;
        int          sz;
        sz  = mq.size();
        byp = model_bypass();
        ev  = (sz != 0) || byp;
        h   = (sz != 0) ? mq[0] : make_entry(bus.in_adef, bus.in_pc, bus.in_inst);
        chk("m_out_valid", 32'(bus.out_valid), 32'(ev));
        chk("m_count", 32'(count), 32'(sz));
        chk("m_pc_wen", 32'(bus.pc_wen), 32'((DEPTH - sz) > SKID));
        if (ev) begin
            chk("m_out_pc", bus.out_pc, h.pc);
            chk("m_out_adef", 32'(bus.out_adef), 32'(h.adef));
            chk("m_out_inst", bus.out_inst, h.adef ? 32'h0 : h.inst);
        end
    endtask

    // One clock: drive inputs, check pre-edge, advance DUT and model.
    task automatic step(input logic fl, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic ad, input logic rdy);
        logic        byp;
        logic        ev;
        logic        pop;
        logic        acc;
        ibuf_entry_t e;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.in_adef   = ad;
        bus.out_ready = rdy;
        #1;
        model_check();
        byp = model_bypass();
        ev  = (mq.size() != 0) || byp;
        pop = ev && rdy;
        acc = iv && (drop == 0) && ((mq.size() < DEPTH) || pop);
        e   = make_entry(ad, pc, inst);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            drop = SKID;
        end else begin
            if (drop > 0) drop--;
            if (!(byp && rdy)) begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.in_adef   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        drop = 0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_pc_wen", 32'(bus.pc_wen), 32'h1);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_adef", 32'(bus.out_adef), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        int          c;

        rst_n = 1'b0;
        idle_inputs();

        // Fill with decode stalled: 8 accepted, 9th dropped.
        for (int i = 0; i < 9; i++) begin
            c = (i < 8) ? i + 1 : 8;
            tbl[i].in_valid  = 1'b1;
            tbl[i].pc        = PC_INITIAL + 32'(4 * i);
            tbl[i].ready     = 1'b0;
            tbl[i].exp_valid = 1'b1;
            tbl[i].exp_count = c;
            tbl[i].exp_wen   = (c < 6);
            tbl[i].exp_pc    = PC_INITIAL;
        end
        // Full with simultaneous push and pop.
        tbl[9].in_valid  = 1'b1;
        tbl[9].pc        = PC_INITIAL + 32'h20;
        tbl[9].ready     = 1'b1;
        tbl[9].exp_valid = 1'b1;
        tbl[9].exp_count = 8;
        tbl[9].exp_wen   = 1'b0;
        tbl[9].exp_pc    = PC_INITIAL + 32'h4;
        // Drain: heads 08..1c then 20 last.
        for (int j = 0; j < 8; j++) begin
            c = 7 - j;
            tbl[10+j].in_valid  = 1'b0;
            tbl[10+j].pc        = '0;
            tbl[10+j].ready     = 1'b1;
            tbl[10+j].exp_valid = (c > 0);
            tbl[10+j].exp_count = c;
            tbl[10+j].exp_wen   = (c < 6);
            tbl[10+j].exp_pc    = PC_INITIAL + 32'(8 + 4 * j);
        end

        do_reset();

        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].in_valid, tbl[i].pc, ~tbl[i].pc, 1'b0, tbl[i].ready);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_pc_wen", i), 32'(bus.pc_wen), 32'(tbl[i].exp_wen));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_out_pc", i), bus.out_pc, tbl[i].exp_pc);
        end

        // Flush with five queued entries and a same-cycle push.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, PC_INITIAL + 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd5);
        step(1'b1, 1'b1, PC_INITIAL + 32'h200, 32'h2222_2222, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        step(1'b0, 1'b1, PC_INITIAL + 32'hf00, 32'h3333_0000, 1'b0, 1'b0);
        chk("drop1_count", 32'(count), 32'd0);
        step(1'b0, 1'b1, PC_INITIAL + 32'hf04, 32'h3333_0004, 1'b0, 1'b0);
        chk("drop2_count", 32'(count), 32'd0);
        step(1'b0, 1'b1, 32'h1c00_1000, 32'h4444_4444, 1'b0, 1'b0);
        chk("post_drop_count", 32'(count), 32'd1);
        chk("post_drop_out_pc", bus.out_pc, 32'h1c00_1000);

        // Flush inside the drop window reloads the window.
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, PC_INITIAL + 32'h300, 32'h5, 1'b0, 1'b0);
        step(1'b1, 1'b1, PC_INITIAL + 32'h304, 32'h6, 1'b0, 1'b0);
        step(1'b0, 1'b1, PC_INITIAL + 32'h308, 32'h7, 1'b0, 1'b0);
        step(1'b0, 1'b1, PC_INITIAL + 32'h30c, 32'h8, 1'b0, 1'b0);
        chk("reload_count", 32'(count), 32'd0);
        step(1'b0, 1'b1, PC_INITIAL + 32'h400, 32'h9, 1'b0, 1'b0);
        chk("reload_accept_count", 32'(count), 32'd1);
        chk("reload_accept_pc", bus.out_pc, PC_INITIAL + 32'h400);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        // Misaligned fetch: instruction word masked at the head.
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h1c00_0002;
        bus.in_inst   = 32'hdead_beef;
        bus.in_adef   = 1'b1;
        bus.out_ready = 1'b0;
        #1;
`ifdef IBUF_BYPASS_EN
        chk("adef_byp_valid", 32'(bus.out_valid), 32'h1);
        chk("adef_byp_adef", 32'(bus.out_adef), 32'h1);
        chk("adef_byp_inst", bus.out_inst, 32'h0);
`else
        chk("adef_nobyp_valid", 32'(bus.out_valid), 32'h0);
`endif
        step(1'b0, 1'b1, 32'h1c00_0002, 32'hdead_beef, 1'b1, 1'b0);
        chk("adef_out_adef", 32'(bus.out_adef), 32'h1);
        chk("adef_out_inst", bus.out_inst, 32'h0);
        chk("adef_out_pc", bus.out_pc, 32'h1c00_0002);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("adef_pop_count", 32'(count), 32'd0);

        // Reset mid-operation clears occupancy and the drop window.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, PC_INITIAL + 32'h500 + 32'(4 * i), 32'h6, 1'b0, 1'b0);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        drop = 0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_pc_wen", 32'(bus.pc_wen), 32'h1);
        rst_n = 1'b1;
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        drop  = 0;
        rst_n = 1'b1;
        step(1'b0, 1'b1, PC_INITIAL + 32'h600, 32'h7777_7777, 1'b0, 1'b0);
        chk("midrst_drop_cleared", 32'(count), 32'd1);
        chk("midrst_head_pc", bus.out_pc, PC_INITIAL + 32'h600);

        // Randomized traffic against the model.
        rpc = PC_INITIAL + 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            logic fl;
            logic iv;
            logic ad;
            logic rdy;
            fl  = ($urandom_range(0, 24) == 0);
            iv  = ($urandom_range(0, 9) < 7);
            ad  = ($urandom_range(0, 15) == 0);
            rdy = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(fl, iv, ad ? (rpc | 32'h2) : rpc, $urandom, ad, rdy);
            if (iv) rpc = rpc + 32'h4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_inst_buffer.md
Name: if_inst_buffer

Overview:
- Instruction fetch buffer at the IF2/ID boundary. It consumes the fetch stream produced by the IF1 PC generator: {pc, instruction, address-fault flag}.
- Queues fetched entries for decode and drives pc_wen back to the PC generator as fetch-side backpressure.
- On backend redirect (pc_is_wrong), flushes all queued entries and discards wrong-path fetches still in flight.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- SKID, 2, fetches that can be in flight between pc_wen deassertion and arrival at in_valid; also the number of post-flush cycles during which arrivals are dropped.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  backend redirect (same signal as pc_is_wrong into the PC generator).
- in_valid  input  1  fetch result valid this cycle.
- in_pc  input  32  PC of fetched instruction.
- in_inst  input  32  instruction word from icache.
- in_adef  input  1  fetch address misaligned (pc[1:0] != 0).
- pc_wen  output  1  PC-advance enable to PC generator.
- out_valid  output  1  head entry valid toward decode.
- out_ready  input  1  decode accepts head entry.
- out_pc  output  32  head PC.
- out_inst  output  32  head instruction; 32'h0 when the head entry has adef set.
- out_adef  output  1  head address-fault flag.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_n=0 at posedge clk): head=tail=0, count=0, drop counter=0. Outputs: out_valid=0, pc_wen=1, count=0, out_pc/out_inst/out_adef=0.
- Storage: circular array of DEPTH entries, each {pc, inst, adef} (65 bits). Head and tail pointers carry an extra wrap bit.
  - empty: head==tail.
  - full: indices equal and wrap bits differ.
- push = in_valid && !flush && drop_cnt==0 && (!full || pop).
- pop = out_valid && out_ready.
- Simultaneous push and pop: both occur. This is allowed when full; count is unchanged.
- Overflow: in_valid while full with no pop. The entry is dropped and the buffer is unchanged. This is a protocol violation.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. one cycle minimum.
- out_* are driven combinationally from the head entry. out_valid = !empty.
- pc_wen = (DEPTH - count) > SKID, combinational from registered count.
  - Guarantees room for SKID in-flight fetches.
  - At DEPTH=8, SKID=2: pc_wen=0 when count >= 6.
- Flush is synchronous and takes priority over all other events:
  - head=tail=0 and count=0 at the next edge.
  - Same-cycle push and pop are both discarded. out_ready is ignored in the flush cycle.
  - drop_cnt loads SKID.
- Post-flush drop window:
  - While drop_cnt != 0, in_valid arrivals are discarded and drop_cnt decrements by 1 per cycle.
  - The first arrival accepted after a flush is on cycle flush+SKID+1.
- Flush while drop_cnt != 0: drop_cnt reloads to SKID.
- Reset mid-operation: identical to the reset state regardless of flush or drop_cnt.
- count arithmetic: count_next = count + push - pop, never outside 0..DEPTH.

Optional Feature:
- Macro IBUF_BYPASS_EN.
- Defined: when empty and push, in_* is forwarded combinationally to out_* with out_valid=1 in the same cycle.
  - If out_ready=1, the entry is consumed without being written and pointers are unchanged.
  - If out_ready=0, it is written normally.
  - Bypass is never taken during flush or the drop window.
- Undefined: no bypass; minimum latency is 1 cycle.

Decomposition:
- Shared defs file: PC_INITIAL (32'h1c00_0000), INST_W=32, PC_W=32, IBUF_ENTRY_W=65, and the entry field bit positions (adef MSB, then pc, then inst).
- One natural sub-module: ibuf_mem, the DEPTH x IBUF_ENTRY_W register array with write port (waddr, wdata, we) and combinational read port. Pointer, count and drop logic stay in if_inst_buffer.

Test Plan:
- Reset then idle: after rst_n=0 for 2 cycles -> out_valid=0, count=0, pc_wen=1.
- Fill with out_ready=0, pushing pc 1c000000,1c000004,... -> pc_wen falls the cycle after count reaches 6. Entries 7-8 (2 skid) are accepted, count=8. A 9th in_valid is dropped and count stays 8.
- Drain with out_ready=1 -> out_pc sequence 1c000000..1c00001c in order, out_valid falls after 8 pops, pc_wen rises when count <= 5.
- Full with simultaneous push (pc 1c000020) and pop -> count stays 8, 1c000020 emerges last.
- Flush with count=5 plus same-cycle push -> count=0 next cycle. Arrivals in the next 2 cycles are discarded. The arrival at cycle flush+3 (pc 1c001000) is the first out_pc.
- in_adef=1 with pc 1c000002 -> out_adef=1, out_inst=0 at head. With IBUF_BYPASS_EN and an empty buffer, out_valid=1 in the same cycle.
